// File: rtl/alu_arith_scheduler.sv
// alu_arith_scheduler
//
// Shares one combinational arithmetic ALU (ADD/SUB/MUL/DIV) among NUM_REQ
// requesters. A round-robin arbiter picks one request while idle, latches its
// operands, holds them on the ALU for a per-op number of cycles, then returns
// the captured result with a one-cycle strobe to the granted requester.
//
// Optional feature macro: ALU_SCHED_DIVZERO_TRAP_EN
//   defined   : adds div_err; DIV by zero returns all-ones and pulses div_err
//   undefined : no div_err port; DIV by zero returns zero
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   req_valid  in   [NUM_REQ]        per-requester request
//   req_op     in   [2*NUM_REQ]      op per requester (00 ADD 01 SUB 10 MUL 11 DIV)
//   req_rs     in   [WIDTH*NUM_REQ]  operand A per requester
//   req_rt     in   [WIDTH*NUM_REQ]  operand B per requester
//   req_ready  out  [NUM_REQ]        one-hot accept strobe (combinational, idle only)
//   alu_op     out  [2]              ALU op select
//   alu_rs     out  [WIDTH]          ALU operand A
//   alu_rt     out  [WIDTH]          ALU operand B
//   alu_result in   [WIDTH]          ALU result
//   resp_valid out  [NUM_REQ]        one-hot, one-cycle result strobe
//   resp_data  out  [WIDTH]          registered result
//   busy       out  1                scheduler not idle
//   div_err    out  1                (macro only) divide-by-zero flag in RESP cycle

module alu_arith_scheduler #(
   parameter int WIDTH      = 8,
   parameter int NUM_REQ    = 4,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [2*NUM_REQ-1:0]     req_op,
   input  logic [WIDTH*NUM_REQ-1:0] req_rs,
   input  logic [WIDTH*NUM_REQ-1:0] req_rt,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [1:0]               alu_op,
   output logic [WIDTH-1:0]         alu_rs,
   output logic [WIDTH-1:0]         alu_rt,
   input  logic [WIDTH-1:0]         alu_result,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]         resp_data,
   output logic                     busy
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
   ,
   output logic                     div_err
`endif
);

   localparam int PW   = $clog2(NUM_REQ);
   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     grant;
   logic [CW-1:0]     count;
   logic [1:0]        op_q;
   logic [WIDTH-1:0]  rs_q;
   logic [WIDTH-1:0]  rt_q;

   logic [PW-1:0]     pick;
   logic [1:0]        sel_op;
   logic [WIDTH-1:0]  sel_rs;
   logic [WIDTH-1:0]  sel_rt;
   logic [CW-1:0]     load_count;
   logic              div_zero;
   logic [WIDTH-1:0]  capture;
   logic [NUM_REQ-1:0] one_hot_base;

   assign one_hot_base = {{(NUM_REQ-1){1'b0}}, 1'b1};

   // Round-robin pick: first pass takes the lowest valid index overall (the
   // wrap-around candidate), second pass overrides it with the lowest valid
   // index at or above rr_ptr when one exists.
   always_comb begin
      pick = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) pick = PW'(i);
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (PW'(i) >= rr_ptr)) pick = PW'(i);
      end
   end

   assign sel_op = req_op[2*pick +: 2];
   assign sel_rs = req_rs[WIDTH*pick +: WIDTH];
   assign sel_rt = req_rt[WIDTH*pick +: WIDTH];

   // Number of EXEC cycles the ALU needs to settle for the selected op.
   always_comb begin
      case (sel_op)
         2'b10:   load_count = CW'(MUL_CYCLES);
         2'b11:   load_count = CW'(DIV_CYCLES);
         default: load_count = CW'(1);
      endcase
   end

   // The ALU output is meaningless for a zero divisor, so the captured value
   // is forced to a fixed pattern instead.
   assign div_zero = (op_q == 2'b11) && (rt_q == '0);
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
   assign capture = div_zero ? {WIDTH{1'b1}} : alu_result;
`else
   assign capture = div_zero ? {WIDTH{1'b0}} : alu_result;
`endif

   assign req_ready  = (state == IDLE && !reset && (|req_valid)) ? (one_hot_base << pick) : '0;
   assign resp_valid = (state == RESP) ? (one_hot_base << grant) : '0;
   assign busy       = (state != IDLE);
   assign alu_op     = op_q;
   assign alu_rs     = rs_q;
   assign alu_rt     = rt_q;

   // Scheduler FSM: accept in IDLE, hold operands through EXEC, strobe the
   // response in RESP and advance the round-robin pointer past the winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant     <= '0;
         count     <= '0;
         op_q      <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         resp_data <= '0;
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
         div_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant <= pick;
                  op_q  <= sel_op;
                  rs_q  <= sel_rs;
                  rt_q  <= sel_rt;
                  count <= load_count;
                  state <= EXEC;
               end
            end
            EXEC: begin
               count <= count - 1'b1;
               if (count == CW'(1)) begin
                  resp_data <= capture;
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
                  div_err   <= div_zero;
`endif
                  state     <= RESP;
               end
            end
            RESP: begin
               rr_ptr <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
               div_err <= 1'b0;
`endif
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arith_scheduler.sv
// tb_alu_arith_scheduler
//
// Directed bench for alu_arith_scheduler with a scoreboard: each accepted
// request pushes its expected responder, data and cycle; a forked monitor
// pops and compares whenever resp_valid is seen.

module tb_alu_arith_scheduler;

   localparam int W = 8;
   localparam int N = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [2*N-1:0]   req_op = '0;
   logic [W*N-1:0]   req_rs = '0;
   logic [W*N-1:0]   req_rt = '0;
   logic [N-1:0]     req_ready;
   logic [1:0]       alu_op;
   logic [W-1:0]     alu_rs;
   logic [W-1:0]     alu_rt;
   logic [W-1:0]     alu_result;
   logic [N-1:0]     resp_valid;
   logic [W-1:0]     resp_data;
   logic             busy;
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
   logic             div_err;
`endif

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;

   alu_arith_scheduler #(
      .WIDTH(W), .NUM_REQ(N), .MUL_CYCLES(2), .DIV_CYCLES(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_op(req_op),
      .req_rs(req_rs),
      .req_rt(req_rt),
      .req_ready(req_ready),
      .alu_op(alu_op),
      .alu_rs(alu_rs),
      .alu_rt(alu_rt),
      .alu_result(alu_result),
      .resp_valid(resp_valid),
      .resp_data(resp_data),
      .busy(busy)
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
      ,
      .div_err(div_err)
`endif
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Cycle counter used to time responses against their accept cycle.
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the shared ALU; a zero divisor yields a junk pattern the
   // scheduler must not pass through.
   always_comb begin
      case (alu_op)
         2'b00:   alu_result = alu_rs + alu_rt;
         2'b01:   alu_result = alu_rs - alu_rt;
         2'b10:   alu_result = alu_rs * alu_rt;
         default: alu_result = (alu_rt == 8'd0) ? 8'h5A : alu_rs / alu_rt;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Present one request (same op/operands on every requester in mask),
   // wait for the grant, check which requester won and queue its result.
   task automatic applyStimulus(input logic [N-1:0] mask, input int idx, input logic [1:0] op,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] expData, input logic expErr,
                                input int lat, input bit push);
      bit   seen = 1'b0;
      exp_t e;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            req_op[2*i +: 2] = op;
            req_rs[W*i +: W] = a;
            req_rt[W*i +: W] = b;
         end
      end
      req_valid = mask;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (req_ready != '0) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         $display("[TB] FAIL grant_timeout: req_ready stayed 0, expected grant to %0d", idx);
      end else begin
         checkOutput("req_ready", 32'(req_ready), 32'(1) << idx);
         if (push) begin
            e.idx = idx; e.data = expData; e.err = expErr; e.cyc = cyc + lat;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      req_valid = '0;
   endtask

   // Wait (bounded) until the scheduler is idle and every response arrived.
   task automatic waitIdle();
      bit done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) done = 1'b1;
      end
      if (!done) begin
         total++;
         $display("[TB] FAIL idle_timeout: busy=%0b pending=%0d, expected idle with none pending", busy, sb.size());
      end
   endtask

   initial begin
      int last;
      int nGrant;
      bit seen;
      exp_t e;

      // Scoreboard monitor, decoupled from stimulus.
      fork
         begin : monitor
            exp_t m;
            forever begin
               @(negedge clk);
               if (resp_valid != '0) begin
                  if (sb.size() == 0) begin
                     total++;
                     $display("[TB] FAIL unexpected_resp: resp_valid=%b, expected no response", resp_valid);
                  end else begin
                     m = sb.pop_front();
                     checkOutput("resp_valid", 32'(resp_valid), 32'(1) << m.idx);
                     checkOutput("resp_data", 32'(resp_data), 32'(m.data));
                     checkOutput("resp_cycle", cyc, m.cyc);
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
                     checkOutput("div_err", 32'(div_err), 32'(m.err));
`endif
                  end
               end
            end
         end
      join_none

      // Reset state, with requests asserted to show req_ready stays low.
      req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 0);
      checkOutput("rst_alu_op", 32'(alu_op), 0);
      checkOutput("rst_alu_rs", 32'(alu_rs), 0);
      checkOutput("rst_alu_rt", 32'(alu_rt), 0);
      checkOutput("rst_resp_data", 32'(resp_data), 0);
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
      checkOutput("rst_div_err", 32'(div_err), 0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = '0;

      // Single ADD on requester 0: 5+3=8, two cycles after accept.
      applyStimulus(4'b0001, 0, 2'b00, 8'd5, 8'd3, 8'd8, 1'b0, 2, 1'b1);
      waitIdle();

      // DIV 100/7=14 on requester 1; ALU inputs held stable through EXEC.
      applyStimulus(4'b0010, 1, 2'b11, 8'd100, 8'd7, 8'd14, 1'b0, 5, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("div_alu_op", 32'(alu_op), 3);
         checkOutput("div_alu_rs", 32'(alu_rs), 100);
         checkOutput("div_alu_rt", 32'(alu_rt), 7);
         checkOutput("div_busy", 32'(busy), 1);
      end
      @(negedge clk);
      checkOutput("div_busy_resp", 32'(busy), 1);
      waitIdle();

      // MUL 20*20=400 truncates to 0x90; SUB 3-5 wraps to 0xFE.
      applyStimulus(4'b1000, 3, 2'b10, 8'd20, 8'd20, 8'h90, 1'b0, 3, 1'b1);
      waitIdle();
      applyStimulus(4'b0001, 0, 2'b01, 8'd3, 8'd5, 8'hFE, 1'b0, 2, 1'b1);
      waitIdle();

      // Divide by zero on requester 1.
`ifdef ALU_SCHED_DIVZERO_TRAP_EN
      applyStimulus(4'b0010, 1, 2'b11, 8'd9, 8'd0, 8'hFF, 1'b1, 5, 1'b1);
`else
      applyStimulus(4'b0010, 1, 2'b11, 8'd9, 8'd0, 8'h00, 1'b0, 5, 1'b1);
`endif
      waitIdle();

      // Fairness: pulse reset so rr_ptr=0, hold all four requests.
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_op[2*i +: 2] = 2'b00;
         req_rs[W*i +: W] = 8'(10 + i);
         req_rt[W*i +: W] = 8'(i);
      end
      req_valid = '1;
      last = 0;
      for (nGrant = 0; nGrant < 5; nGrant++) begin
         seen = 1'b0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
         end
         if (!seen) begin
            total++;
            $display("[TB] FAIL fair_timeout: no grant, expected grant %0d", nGrant % 4);
         end else begin
            checkOutput("fair_grant", 32'(req_ready), 32'(1) << (nGrant % 4));
            if (nGrant > 0) checkOutput("fair_spacing", cyc - last, 3);
            e.idx = nGrant % 4; e.data = 8'(10 + 2 * (nGrant % 4)); e.err = 1'b0; e.cyc = cyc + 2;
            sb.push_back(e);
            last = cyc;
         end
         @(posedge clk);
      end
      #1;
      req_valid = '0;
      waitIdle();

      // Wrap/skip: grant 2 leaves rr_ptr=3; lone req 1 must still win,
      // then rr_ptr=2 so req 3 beats req 1.
      applyStimulus(4'b0100, 2, 2'b00, 8'd1, 8'd2, 8'd3, 1'b0, 2, 1'b1);
      waitIdle();
      applyStimulus(4'b0010, 1, 2'b00, 8'd7, 8'd8, 8'd15, 1'b0, 2, 1'b1);
      waitIdle();
      applyStimulus(4'b1010, 3, 2'b00, 8'd40, 8'd2, 8'd42, 1'b0, 2, 1'b1);
      waitIdle();

      // Reset in the first EXEC cycle of a MUL: no response may appear.
      applyStimulus(4'b0100, 2, 2'b10, 8'd6, 8'd7, 8'd42, 1'b0, 3, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_busy", 32'(busy), 0);
      checkOutput("rst_mid_resp_valid", 32'(resp_valid), 0);
      repeat (5) @(negedge clk);

      // rr_ptr is back at 0, so req 0 beats req 3.
      applyStimulus(4'b1001, 0, 2'b00, 8'd1, 8'd1, 8'd2, 1'b0, 2, 1'b1);
      waitIdle();

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
